// File: rtl/rs485_pkg.sv
// Shared types and helpers for the RS-485 transmitter: FSM state encoding,
// default timing constants and the parity function used on frame load.
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
    PARITY,
    STOP,
    TAIL
  } state_t;

  localparam int CLKS_PER_BIT_DEF = 2604;
  localparam int DATA_BITS        = 8;

  // Value of the parity bit for a byte: XOR of data, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/rs485_tx_fifo.sv
// Small synchronous byte FIFO feeding the transmitter; pointers wrap modulo
// depth and a separate occupancy count gives full/empty unambiguously.
module rs485_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // A push is refused while full even when a pop lands on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/rs485_tx.sv
// Half-duplex RS-485 UART transmitter: FIFO-buffered bytes framed as
// start/8 data LSB-first/optional parity/stop, with guarded DE control.
module rs485_tx
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int DE_LEAD      = 64,
  parameter int DE_TAIL      = 2604,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       tx,
  output logic       de,
  output logic       busy,
  output logic       tx_done
);

  localparam int MAX_BL  = (CLKS_PER_BIT > DE_LEAD) ? CLKS_PER_BIT : DE_LEAD;
  localparam int CNT_MAX = (MAX_BL > DE_TAIL) ? MAX_BL : DE_TAIL;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'((DE_LEAD > 0) ? DE_LEAD - 1 : 0);
  localparam logic [CW-1:0] TAIL_LAST = CW'((DE_TAIL > 0) ? DE_TAIL - 1 : 0);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_lim;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n;
  logic        tx_n, de_n;
  logic        bit_end;
  logic        push, pop, full, empty;
  logic [7:0]  head;

  assign push = tx_vld && !full;

  rs485_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tx_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    cnt_lim = BIT_LAST;
    if (state == LEAD)      cnt_lim = LEAD_LAST;
    else if (state == TAIL) cnt_lim = TAIL_LAST;
  end

  assign bit_end = (cnt == cnt_lim);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (!empty) state_n = (DE_LEAD > 0) ? LEAD : START;
      LEAD:   if (bit_end) state_n = START;
      START:  if (bit_end) state_n = DATA;
      DATA:   if (bit_end && bit_idx == IDX_LAST)
                state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_n = STOP;
      // Queued bytes follow immediately; DE is already up so no lead again.
      STOP:   if (bit_end) begin
                if (!empty)           state_n = START;
                else if (DE_TAIL > 0) state_n = TAIL;
                else                  state_n = IDLE;
              end
      TAIL:   if (!empty)       state_n = START;
              else if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The head byte is consumed on the edge that enters START.
  assign pop = (state_n == START) && (state != START);

  always_comb begin
    shift_n   = shift;
    bit_idx_n = bit_idx;
    par_n     = par;
    if (state_n != state || bit_end || state == IDLE) cnt_n = '0;
    else                                               cnt_n = cnt + CNT_ONE;
    if (pop) begin
      shift_n   = head;
      bit_idx_n = '0;
      par_n     = parity_bit(head, PARITY_ODD != 0);
    end else if (state == DATA && bit_end) begin
      shift_n   = shift >> 1;
      bit_idx_n = bit_idx + 3'd1;
    end
  end

  // Line and DE levels are derived from the next state so the registered
  // outputs line up exactly with the state register.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    de_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      de      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_n;
      de      <= de_n;
    end
  end

  assign tx_rdy  = !full;
  assign busy    = (state != IDLE) || !empty;
  assign tx_done = (state == STOP) && bit_end;

endmodule
